// File: rtl/srl_fifo_ctrl_pkg.sv
// Shared constants for the SRL-based short FIFO.
// State encoding and bank geometry.
package srl_fifo_ctrl_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  typedef enum logic {
    EMPTY     = 1'b0,
    NOT_EMPTY = 1'b1
  } state_t;

endpackage

// File: rtl/srl_fifo_ctrl_srl.sv
// srl: 16-deep shift-register bank (SRL16E style), no reset.
// Ports: clk, shift, din[WIDTH], addr[4], dout[WIDTH] (comb from addr).
module srl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic              clk,
  input  logic              shift,
  input  logic [WIDTH-1:0]  din,
  input  logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  dout
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  // Newest word enters at index 0; older words move up.
  always_ff @(posedge clk) begin
    if (shift) begin
      mem <= {mem[DEPTH-2:0], din};
    end
  end

  assign dout = mem[addr];

endmodule

// File: rtl/srl_fifo_ctrl.sv
// srl_fifo_ctrl: sequences an srl bank as a 16-entry FIFO.
// Ports: clk, reset_n, clear, datain/src_rdy_i/dst_rdy_o (write side),
// dataout/src_rdy_o/dst_rdy_i (read side), occupied, space, almost_full.
module srl_fifo_ctrl
  import srl_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int AFULL = 12
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [WIDTH-1:0] datain,
  input  logic             src_rdy_i,
  output logic             dst_rdy_o,
  output logic [WIDTH-1:0] dataout,
  output logic             src_rdy_o,
  input  logic             dst_rdy_i,
  output logic [4:0]       occupied,
  output logic [4:0]       space,
  output logic             almost_full
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] a, a_nxt;
  logic              wr, rd, full;

  assign wr = src_rdy_i & dst_rdy_o;
  assign rd = dst_rdy_i & src_rdy_o;

  // Oldest entry always sits at address a.
  srl #(
    .WIDTH (WIDTH)
  ) u_srl (
    .clk   (clk),
    .shift (wr),
    .din   (datain),
    .addr  (a),
    .dout  (dataout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= EMPTY;
      a     <= '0;
    end else begin
      state <= state_nxt;
      a     <= a_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    a_nxt     = a;
    if (clear) begin
      state_nxt = EMPTY;
      a_nxt     = '0;
    end else begin
      case (state)
        EMPTY: begin
          if (wr) state_nxt = NOT_EMPTY;
        end
        NOT_EMPTY: begin
          // Simultaneous wr/rd: shift and pop cancel.
          unique case (1'b1)
            (wr & ~rd): a_nxt = a + 4'd1;
            (rd & ~wr): begin
              if (a == '0) state_nxt = EMPTY;
              else         a_nxt     = a - 4'd1;
            end
            default: ;
          endcase
        end
        default: begin
          state_nxt = EMPTY;
          a_nxt     = '0;
        end
      endcase
    end
  end

  always_comb begin
    full        = (state == NOT_EMPTY) && (a == 4'd15);
    dst_rdy_o   = ~full;
    src_rdy_o   = (state == NOT_EMPTY);
    occupied    = (state == NOT_EMPTY) ? ({1'b0, a} + 5'd1) : 5'd0;
    space       = 5'(DEPTH) - occupied;
    almost_full = (occupied >= 5'(AFULL));
  end

endmodule

// File: tb/tb_srl_fifo_ctrl.sv
// Directed bench for srl_fifo_ctrl.
// Hand-computed expectations; one check task.
module tb_srl_fifo_ctrl;

  localparam int WIDTH = 18;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             clear;
  logic [WIDTH-1:0] datain;
  logic             src_rdy_i;
  logic             dst_rdy_o;
  logic [WIDTH-1:0] dataout;
  logic             src_rdy_o;
  logic             dst_rdy_i;
  logic [4:0]       occupied;
  logic [4:0]       space;
  logic             almost_full;

  int errors = 0;
  int checks = 0;

  srl_fifo_ctrl #(
    .WIDTH (WIDTH),
    .AFULL (12)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .clear       (clear),
    .datain      (datain),
    .src_rdy_i   (src_rdy_i),
    .dst_rdy_o   (dst_rdy_o),
    .dataout     (dataout),
    .src_rdy_o   (src_rdy_o),
    .dst_rdy_i   (dst_rdy_i),
    .occupied    (occupied),
    .space       (space),
    .almost_full (almost_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int v);
    datain    = WIDTH'(v);
    src_rdy_i = 1'b1;
    step();
    src_rdy_i = 1'b0;
  endtask

  task automatic drain(input string tag, input int first, input int n);
    dst_rdy_i = 1'b1;
    for (int i = 0; i < n; i++) begin
      check(tag, 32'(dataout), 32'(first + i));
      step();
    end
    dst_rdy_i = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    clear     = 1'b0;
    datain    = '0;
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    step();

    check("rst_src_rdy", 32'(src_rdy_o), 0);
    check("rst_dst_rdy", 32'(dst_rdy_o), 1);
    check("rst_occ", 32'(occupied), 0);
    check("rst_space", 32'(space), 16);
    check("rst_afull", 32'(almost_full), 0);

    push('hAB);
    check("one_src_rdy", 32'(src_rdy_o), 1);
    check("one_data", 32'(dataout), 'hAB);
    check("one_occ", 32'(occupied), 1);
    dst_rdy_i = 1'b1;
    step();
    dst_rdy_i = 1'b0;
    check("one_pop_src_rdy", 32'(src_rdy_o), 0);
    check("one_pop_occ", 32'(occupied), 0);

    for (int i = 1; i <= 16; i++) begin
      push(i);
      check($sformatf("fill_afull_%0d", i), 32'(almost_full),
            (i >= 12) ? 1 : 0);
    end
    check("full_dst_rdy", 32'(dst_rdy_o), 0);
    check("full_occ", 32'(occupied), 16);
    check("full_space", 32'(space), 0);
    push(99);
    check("full_reject_occ", 32'(occupied), 16);
    drain("fill_drain", 1, 16);
    check("fill_empty_src", 32'(src_rdy_o), 0);
    check("fill_empty_occ", 32'(occupied), 0);

    for (int i = 0; i < 5; i++) push(100 + i);
    src_rdy_i = 1'b1;
    dst_rdy_i = 1'b1;
    for (int k = 0; k < 20; k++) begin
      datain = WIDTH'(105 + k);
      check("rw_head", 32'(dataout), 32'(100 + k));
      step();
      check("rw_occ", 32'(occupied), 5);
    end
    src_rdy_i = 1'b0;
    dst_rdy_i = 1'b0;
    drain("rw_drain", 120, 5);

    for (int i = 0; i < 16; i++) push(200 + i);
    datain    = WIDTH'(300);
    src_rdy_i = 1'b1;
    dst_rdy_i = 1'b1;
    step();
    dst_rdy_i = 1'b0;
    check("fullrw_occ", 32'(occupied), 15);
    check("fullrw_dst_rdy", 32'(dst_rdy_o), 1);
    datain = WIDTH'(301);
    step();
    src_rdy_i = 1'b0;
    check("fullrw_refill", 32'(occupied), 16);
    drain("fullrw_drain", 201, 15);
    check("fullrw_last", 32'(dataout), 301);
    dst_rdy_i = 1'b1;
    step();
    dst_rdy_i = 1'b0;
    check("fullrw_empty", 32'(occupied), 0);

    for (int i = 0; i < 7; i++) push(400 + i);
    check("clr_pre_occ", 32'(occupied), 7);
    clear     = 1'b1;
    datain    = WIDTH'(500);
    src_rdy_i = 1'b1;
    step();
    clear     = 1'b0;
    src_rdy_i = 1'b0;
    check("clr_occ", 32'(occupied), 0);
    check("clr_src_rdy", 32'(src_rdy_o), 0);
    push('h123);
    check("clr_head", 32'(dataout), 'h123);
    check("clr_head_occ", 32'(occupied), 1);
    dst_rdy_i = 1'b1;
    step();
    dst_rdy_i = 1'b0;

    for (int i = 0; i < 9; i++) push(600 + i);
    check("arst_pre_occ", 32'(occupied), 9);
    #2 reset_n = 1'b0;
    #1;
    check("arst_occ", 32'(occupied), 0);
    check("arst_space", 32'(space), 16);
    check("arst_src_rdy", 32'(src_rdy_o), 0);
    check("arst_dst_rdy", 32'(dst_rdy_o), 1);
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    step();
    check("arst_post_occ", 32'(occupied), 0);
    push('h77);
    push('h78);
    check("arst_post_occ2", 32'(occupied), 2);
    drain("arst_drain", 'h77, 2);
    check("arst_final_src", 32'(src_rdy_o), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/srl_fifo_ctrl.md
Name: srl_fifo_ctrl

Overview:
- Controller that sequences a 16-deep SRL16E shift-register bank (`srl` module) as a short FIFO.
- Generates the shift enable and the read address for the bank, and tracks occupancy.
- Presents src_rdy/dst_rdy streaming handshakes on both sides.
- Used as a small elastic buffer between packet-path pipeline stages where block RAM is wasteful.

Parameters:
- WIDTH, 18, data width in bits; passed to the `srl` instance.
- AFULL, 12, occupancy at or above which almost_full asserts; legal range 1..16.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous flush; empties the FIFO.
- datain  input  WIDTH  write data.
- src_rdy_i  input  1  upstream has valid datain.
- dst_rdy_o  output  1  FIFO can accept (not full).
- dataout  output  WIDTH  head-of-FIFO data.
- src_rdy_o  output  1  dataout valid (not empty).
- dst_rdy_i  input  1  downstream accepts dataout.
- occupied  output  5  entries held, 0..16.
- space  output  5  free entries, 16-occupied.
- almost_full  output  1  occupied >= AFULL.

Behaviour:
- Handshake terms:
  - wr = src_rdy_i & dst_rdy_o.
  - rd = dst_rdy_i & src_rdy_o.
  - A transfer occurs on a clock edge where its term is high.
- Datapath connection:
  - The bank's shift enable is driven by wr.
  - The bank's data input is driven by datain.
  - The bank's 4-bit address is driven by register a.
  - dataout is the bank output, combinational from a.
  - The oldest entry is always at address a.
- State machine: two states, EMPTY and NOT_EMPTY, plus a 4-bit address register a.
- Reset (async, reset_n=0):
  - state=EMPTY, a=0.
  - Outputs: dst_rdy_o=1, src_rdy_o=0, occupied=0, space=16, almost_full=0 (AFULL>=1).
  - SRL contents are not reset; dataout is don't-care while empty.
- EMPTY state:
  - wr -> NOT_EMPTY, a stays 0.
  - rd cannot occur.
- NOT_EMPTY state:
  - wr & ~rd: a <= a+1. Cannot wrap, because wr requires not full.
  - rd & ~wr:
    - if a==0 -> EMPTY (a stays 0);
    - else a <= a-1.
  - wr & rd: a and state unchanged. The shift and the pop cancel; the new head is at the same address.
- Status decoding:
  - full = (state==NOT_EMPTY) & (a==15).
  - dst_rdy_o = ~full.
  - src_rdy_o = (state==NOT_EMPTY).
  - occupied = EMPTY ? 0 : a+1, computed in 5 bits.
  - space = 16 - occupied.
  - almost_full = (occupied >= AFULL).
  - All status outputs derive from registered state/a only; there is no combinational path from the *_i inputs to the *_o outputs.
- Latency:
  - A word written at edge N is visible on dataout with src_rdy_o=1 after edge N (one cycle when the FIFO was empty).
  - Throughput is one word per cycle in each direction.
- Full boundary: when full, dst_rdy_o=0, so src_rdy_i is ignored. A simultaneous read still pops, and dst_rdy_o rises the next cycle. No write-through when full.
- Empty boundary: when empty, src_rdy_o=0 and dst_rdy_i is ignored. No read-through of a same-cycle write.
- clear:
  - Takes priority over wr/rd: next state=EMPTY, a=0.
  - A concurrent write still shifts the bank (shift enable is tied to wr), but that entry is discarded.
- Reset asserted mid-transfer: the FIFO empties immediately and asynchronously; in-flight words are lost.

Decomposition:
- Shared package: state encoding constants (EMPTY=1'b0, NOT_EMPTY=1'b1) and DEPTH=16 / ADDR_W=4 constants.
- One sub-module: the existing `srl` shift-register bank, instantiated with WIDTH. All control lives in srl_fifo_ctrl.

Test Plan:
- Reset: release reset_n with no traffic -> src_rdy_o=0, dst_rdy_o=1, occupied=0, space=16, almost_full=0.
- Single word: write 0x00AB with dst_rdy_i=0 -> next cycle src_rdy_o=1, dataout=0x00AB, occupied=1. Then pulse dst_rdy_i -> src_rdy_o=0, occupied=0.
- Fill to full: write 1..16 back-to-back with dst_rdy_i=0 -> almost_full first rises after the 12th write. After the 16th: dst_rdy_o=0, occupied=16, space=0. A 17th attempt (value 99) is not stored. Draining yields 1..16 in order.
- Simultaneous read/write at occupancy 5: hold src_rdy_i=dst_rdy_i=1 for 20 cycles with incrementing data -> occupied stays 5, output order preserved. Repeat at full: a read frees a slot and the next write is accepted.
- clear with src_rdy_i=1 at occupancy 7 -> next cycle occupied=0, src_rdy_o=0. The following write of 0x0123 appears as the head.
- Async reset mid-stream (reset_n low between edges at occupancy 9) -> outputs go to reset values without waiting for a clock edge. After release, a fresh write/read sequence is correct.
